// File: rtl/cp0_pkg.sv
// Shared coprocessor-0 definitions: FSM state encoding and interrupt-controller register map.
package cp0_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] REG_ENABLE  = 2'd0;
  localparam logic [1:0] REG_PENDING = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;

endpackage

// File: rtl/prio_enc_lsb.sv
// Combinational priority encoder: reports the index of the lowest set bit.
module prio_enc_lsb #(
  parameter int N    = 8,
  parameter int ID_W = 3
) (
  input  logic [N-1:0]    vec,
  output logic            valid,
  output logic [ID_W-1:0] id
);

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    valid = |vec;
    id    = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (vec[i-1]) id = ID_W'(i - 1);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-latched pending bits, enable mask, fixed-priority
// request to coprocessor 0 held until taken, then blocked until eret.
module irq_ctrl
  import cp0_pkg::*;
#(
  parameter int N_IRQ = 8,
  parameter int ID_W  = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_IRQ-1:0] i_irq,
  input  logic             i_we,
  input  logic [31:0]      i_addr,
  input  logic [31:0]      i_data,
  output logic [31:0]      o_data,
  input  logic             i_cp0_ack,
  input  logic             i_eret,
  output logic             o_interrupt,
  output logic [ID_W-1:0]  o_irq_id,
  output logic             o_busy
);

  state_t           state, state_nxt;
  logic [N_IRQ-1:0] enable, pending, pending_nxt, irq_q, events, masked;
  logic [ID_W-1:0]  cur_id, sel_id;
  logic             sel_valid;
  logic             unused_bits;

  assign unused_bits = ^{i_addr[31:2], i_data};

  assign events = i_irq & ~irq_q;
  assign masked = pending & enable;

  prio_enc_lsb #(.N(N_IRQ), .ID_W(ID_W)) u_prio (
    .vec  (masked),
    .valid(sel_valid),
    .id   (sel_id)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (sel_valid) state_nxt = ST_REQ;
      ST_REQ: begin
        if (i_cp0_ack)            state_nxt = ST_SERVICE;
        else if (!enable[cur_id]) state_nxt = ST_IDLE;
      end
      ST_SERVICE: if (i_eret) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // New events are applied last so they override both W1C and ack clears.
  always_comb begin
    pending_nxt = pending;
    if (i_we && i_addr[1:0] == REG_PENDING) pending_nxt = pending_nxt & ~i_data[N_IRQ-1:0];
    if (state == ST_REQ && i_cp0_ack) pending_nxt[cur_id] = 1'b0;
    pending_nxt = pending_nxt | events;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      irq_q   <= '0;
      pending <= '0;
      enable  <= '0;
      cur_id  <= '0;
    end else begin
      irq_q   <= i_irq;
      pending <= pending_nxt;
      if (i_we && i_addr[1:0] == REG_ENABLE) enable <= i_data[N_IRQ-1:0];
      if (state == ST_IDLE && sel_valid) cur_id <= sel_id;
    end
  end

  assign o_interrupt = (state == ST_REQ);
  assign o_busy      = (state != ST_IDLE);
  assign o_irq_id    = cur_id;

  always_comb begin
    o_data = '0;
    case (i_addr[1:0])
      REG_ENABLE:  o_data[N_IRQ-1:0] = enable;
      REG_PENDING: o_data[N_IRQ-1:0] = pending;
      REG_STATUS: begin
        o_data[31]       = o_busy;
        o_data[30]       = o_interrupt;
        o_data[ID_W-1:0] = cur_id;
      end
      default:     o_data = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Randomized bench for irq_ctrl against a behavioural reference model, plus directed scenarios.
module tb_irq_ctrl;

  localparam int N  = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq;
  logic          we, ack, eret;
  logic [31:0]   addr, data, rdata;
  logic          intr, busy;
  logic [IW-1:0] id;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: phase 0 = idle, 1 = requesting, 2 = in service
  logic [N-1:0] m_en, m_pend, m_prev;
  int           m_phase, m_cur;

  irq_ctrl #(.N_IRQ(N), .ID_W(IW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_irq      (irq),
    .i_we       (we),
    .i_addr     (addr),
    .i_data     (data),
    .o_data     (rdata),
    .i_cp0_ack  (ack),
    .i_eret     (eret),
    .o_interrupt(intr),
    .o_irq_id   (id),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r[N-1:0] = m_en;
      2'd1: r[N-1:0] = m_pend;
      2'd2: begin
        r[31]     = (m_phase != 0);
        r[30]     = (m_phase == 1);
        r[IW-1:0] = m_cur[IW-1:0];
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_en = '0; m_pend = '0; m_prev = '0; m_phase = 0; m_cur = 0;
  endtask

  // One clock edge of the specified behaviour, evaluated on pre-edge values.
  task automatic model_edge();
    logic [N-1:0] ev, np, x;
    ev = irq & ~m_prev;
    np = m_pend;
    if (we && addr[1:0] == 2'd1) np = np & ~data[N-1:0];
    if (m_phase == 1 && ack) np[m_cur] = 1'b0;
    np = np | ev;
    x = m_pend & m_en;
    case (m_phase)
      0: if (x != 0) begin
           m_cur   = $clog2(x & (~x + 1'b1));
           m_phase = 1;
         end
      1: if (ack) m_phase = 2;
         else if (!m_en[m_cur]) m_phase = 0;
      default: if (eret) m_phase = 0;
    endcase
    if (we && addr[1:0] == 2'd0) m_en = data[N-1:0];
    m_pend = np;
    m_prev = irq;
  endtask

  task automatic check_outputs();
    check("interrupt", {31'd0, intr}, {31'd0, m_phase == 1});
    check("busy", {31'd0, busy}, {31'd0, m_phase != 0});
    check("irq_id", 32'(id), 32'(m_cur));
  endtask

  task automatic step(input logic [N-1:0] irq_v, input logic we_v, input logic [1:0] addr_v,
                      input logic [31:0] data_v, input logic ack_v, input logic eret_v);
    irq = irq_v; we = we_v; addr = {30'd0, addr_v}; data = data_v; ack = ack_v; eret = eret_v;
    #1 check("rdata", rdata, m_read(addr_v));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic peek(input logic [1:0] a, input logic [31:0] exp, input string tag);
    we = 1'b0; addr = {30'd0, a};
    #1 check(tag, rdata, exp);
  endtask

  // Reset asserted between edges must clear outputs before the next edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    addr = 32'd0; we = 1'b0;
    #1;
    check("arst_int", {31'd0, intr}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_id", 32'(id), 32'd0);
    check("arst_enable", rdata, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] irq_r, flip;
    logic [31:0]  rnd;

    rst = 1'b1; irq = 8'h01; we = 1'b0; addr = '0; data = '0; ack = 1'b0; eret = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_int", {31'd0, intr}, 32'd0);
    peek(2'd1, 32'd0, "rst_pend");
    model_reset();
    irq = '0;
    rst = 1'b0;

    // Enable and basic request latency
    step(8'h00, 1, 2'd0, 32'h01, 0, 0);
    step(8'h01, 0, 2'd0, 32'h00, 0, 0);
    check("t1_no_int_yet", {31'd0, intr}, 32'd0);
    step(8'h00, 0, 2'd0, 32'h00, 0, 0);
    check("t1_int", {31'd0, intr}, 32'd1);
    check("t1_id", 32'(id), 32'd0);
    peek(2'd2, 32'hC000_0000, "t1_status");
    step(8'h00, 0, 2'd0, 32'h00, 1, 0);
    check("t1_ack_int", {31'd0, intr}, 32'd0);
    check("t1_ack_busy", {31'd0, busy}, 32'd1);
    peek(2'd1, 32'd0, "t1_pend_clr");
    step(8'h00, 0, 2'd0, 32'h00, 0, 1);
    check("t1_eret_busy", {31'd0, busy}, 32'd0);

    // Fixed priority and blocking during service
    step(8'h00, 1, 2'd0, 32'hFF, 0, 0);
    step(8'h24, 0, 2'd0, 32'h00, 0, 0);
    step(8'h00, 0, 2'd0, 32'h00, 0, 0);
    check("prio_id2", 32'(id), 32'd2);
    step(8'h00, 0, 2'd0, 32'h00, 1, 0);
    step(8'h00, 0, 2'd0, 32'h00, 0, 1);
    check("prio_idle", {31'd0, intr}, 32'd0);
    step(8'h00, 0, 2'd0, 32'h00, 0, 0);
    check("prio_int5", {31'd0, intr}, 32'd1);
    check("prio_id5", 32'(id), 32'd5);
    step(8'h00, 0, 2'd0, 32'h00, 1, 0);
    step(8'h02, 0, 2'd0, 32'h00, 0, 0);
    step(8'h00, 0, 2'd0, 32'h00, 0, 0);
    step(8'h00, 0, 2'd0, 32'h00, 0, 0);
    check("svc_blocked", {31'd0, intr}, 32'd0);
    step(8'h00, 0, 2'd0, 32'h00, 0, 1);
    check("eret_no_int", {31'd0, intr}, 32'd0);
    step(8'h00, 0, 2'd0, 32'h00, 0, 0);
    check("after_eret_id1", 32'(id), 32'd1);
    step(8'h00, 0, 2'd0, 32'h00, 1, 0);
    step(8'h00, 0, 2'd0, 32'h00, 0, 1);

    // Masking while requesting
    step(8'h00, 1, 2'd0, 32'h08, 0, 0);
    step(8'h08, 0, 2'd0, 32'h00, 0, 0);
    step(8'h00, 0, 2'd0, 32'h00, 0, 0);
    check("mask_req", {31'd0, intr}, 32'd1);
    step(8'h00, 1, 2'd0, 32'h00, 0, 0);
    step(8'h00, 0, 2'd0, 32'h00, 0, 0);
    check("mask_drop", {31'd0, intr}, 32'd0);
    check("mask_idle", {31'd0, busy}, 32'd0);
    peek(2'd1, 32'h08, "mask_pend_kept");
    step(8'h00, 1, 2'd0, 32'h08, 0, 0);
    step(8'h00, 0, 2'd0, 32'h00, 0, 0);
    check("mask_rereq", {31'd0, intr}, 32'd1);
    step(8'h00, 0, 2'd0, 32'h00, 1, 0);
    step(8'h00, 0, 2'd0, 32'h00, 0, 1);

    // W1C versus a simultaneous event, and a held-high line
    step(8'h00, 1, 2'd0, 32'h00, 0, 0);
    step(8'h10, 1, 2'd1, 32'h10, 0, 0);
    peek(2'd1, 32'h10, "w1c_event_wins");
    step(8'h10, 1, 2'd1, 32'h10, 0, 0);
    peek(2'd1, 32'h00, "w1c_clear");
    step(8'h10, 0, 2'd0, 32'h00, 0, 0);
    step(8'h10, 0, 2'd0, 32'h00, 0, 0);
    peek(2'd1, 32'h00, "held_no_repend");

    // Asynchronous reset in service
    step(8'h00, 1, 2'd0, 32'h01, 0, 0);
    step(8'h01, 0, 2'd0, 32'h00, 0, 0);
    step(8'h00, 0, 2'd0, 32'h00, 0, 0);
    step(8'h00, 0, 2'd0, 32'h00, 1, 0);
    check("svc_before_rst", {31'd0, busy}, 32'd1);
    async_reset();

    // Randomized traffic with occasional mid-flight resets
    irq_r = '0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(99) == 0) begin
        async_reset();
      end else begin
        rnd   = $urandom & $urandom & $urandom;
        flip  = rnd[N-1:0];
        irq_r = irq_r ^ flip;
        step(irq_r, ($urandom_range(3) == 0), 2'($urandom_range(3)), $urandom,
             ($urandom_range(2) == 0), ($urandom_range(3) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller that arbitrates N external interrupt lines onto the single external-interrupt input of the coprocessor 0 block.
- Latches rising edges into pending bits and masks them with a software enable register.
- Selects one source by fixed priority, holds the request until coprocessor 0 takes it, then blocks further requests until the handler executes eret.
- Sits beside coproc0 in the CPU top and shares the same register write/read bus style.

Parameters:
- N_IRQ, 8, number of external interrupt lines (2..32).
- ID_W, 3, width of the source-id field; must equal clog2(N_IRQ).

Ports:
- i_clk  input  1  system clock; all state updates on rising edge.
- i_rst  input  1  reset; asynchronous, active-high.
- i_irq  input  N_IRQ  external interrupt lines; synchronous to i_clk, level; a rising edge is an event.
- i_we  input  1  register write enable.
- i_addr  input  32  register address; only i_addr[1:0] decoded.
- i_data  input  32  register write data.
- o_data  output  32  register read data (combinational from i_addr).
- i_cp0_ack  input  1  coproc0 interrupt-taken indication (coproc0 o_interrupt).
- i_eret  input  1  eret instruction executing.
- o_interrupt  output  1  request to coproc0 i_interrupt.
- o_irq_id  output  ID_W  id of the source currently requested or in service.
- o_busy  output  1  high in REQ or SERVICE.

Behaviour:
- Design has one clock; reset is asynchronous, active-high.
- Reset values: enable=0, pending=0, irq_q=0, state=IDLE, cur_id=0, o_interrupt=0, o_irq_id=0, o_busy=0.
- Edge detect: irq_q <= i_irq each cycle. Event = i_irq & ~irq_q; on the same edge it sets pending[i].
- Register map, word-selected by i_addr[1:0]:
  - 0 ENABLE, RW, bits [N_IRQ-1:0].
  - 1 PENDING, read; a write with i_we is write-1-to-clear.
  - 2 STATUS, read-only: bit31=o_busy, bit30=o_interrupt, [ID_W-1:0]=cur_id.
  - 3 reads 0.
  - Unused upper bits read 0. Writes to 2 and 3 are ignored.
- Pending-bit priority: a set from a new event wins over a W1C clear in the same cycle. A clear caused by ack wins over nothing else; if an event on cur_id coincides with the ack, the bit stays set.
- FSM states are IDLE, REQ and SERVICE.
  - IDLE: if (pending & enable) != 0, then cur_id <= lowest set index, o_interrupt <= 1, go to REQ. Otherwise stay in IDLE.
  - REQ: o_interrupt held at 1.
    - If i_cp0_ack=1: pending[cur_id] <= 0, o_interrupt <= 0, go to SERVICE.
    - Else if enable[cur_id]==0 (masked while requesting): o_interrupt <= 0, go to IDLE; the pending bit is kept.
    - A higher-priority source arriving in REQ does not preempt. cur_id is stable until exit.
  - SERVICE: o_interrupt=0. On i_eret=1, go to IDLE; arbitration resumes on the following edge.
- i_eret in IDLE or REQ is ignored.
- i_cp0_ack outside REQ is ignored.
- Latency:
  - i_irq rises before edge k → pending visible after edge k → o_interrupt=1 after edge k+1.
  - Ack sampled at edge m → o_interrupt=0 after edge m.
  - eret at edge e → earliest new o_interrupt after edge e+1.
- o_busy = (state != IDLE). o_irq_id = cur_id, which holds its last value in IDLE.
- A level held high produces exactly one event. The line must fall and rise again to re-pend.
- Asserting i_rst mid-REQ or mid-SERVICE returns everything to reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package cp0_pkg holds:
  - state encoding localparams: ST_IDLE=2'd0, ST_REQ=2'd1, ST_SERVICE=2'd2;
  - register word addresses: REG_ENABLE=2'd0, REG_PENDING=2'd1, REG_STATUS=2'd2.
- One sub-module, prio_enc_lsb: a combinational lowest-set-bit priority encoder with inputs N_IRQ vector and outputs {valid, id}, reusable elsewhere.

Test Plan:
- Reset and enable: with i_rst high, assert i_irq=8'h01 → o_interrupt=0 and pending=0; release reset, write ENABLE=8'h01, pulse i_irq[0] → o_interrupt=1 two edges later, o_irq_id=0, STATUS=32'hC0000000.
- Priority: ENABLE=8'hFF, raise i_irq[5] and i_irq[2] in the same cycle → o_irq_id=2. After ack, eret and one idle edge → o_irq_id=5 is requested, o_interrupt=1.
- Ack and eret: in REQ drive i_cp0_ack=1 one cycle → o_interrupt=0, PENDING bit cleared, o_busy=1. Raise another enabled line → no request until i_eret pulses. Request appears one edge after returning to IDLE.
- Masking: pending[3]=1, ENABLE=8'h08 → REQ; write ENABLE=0 → next edge o_interrupt=0, state IDLE, PENDING still 8'h08. Re-enable → request again.
- W1C vs event: write PENDING=8'h10 in the same cycle i_irq[4] rises → PENDING bit 4 remains 1. Write 8'h10 on a later quiet cycle → bit 4 becomes 0. A held-high line does not re-pend.
- Async reset mid-SERVICE: assert i_rst between clock edges → o_busy, o_interrupt, o_irq_id and ENABLE read 0 before the next edge.
